im_loader: RTL and testbench
============================

# im_loader

Boot-time program loader sitting directly upstream of the accumulator CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the instruction memory's write port. It holds the CPU in reset until the image is fully written, so the program counter starts fetching from address 0 of a complete image.

## Interface
- `ADDR_W`, 5, instruction-memory address width; maximum image size is 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5, header byte that starts a load.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `im_a`  out  ADDR_W  instruction-memory write address; drives the IM `a` input while loading.
- `im_d`  out  16  instruction-memory write data.
- `im_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `cpu_rst`  out  1  reset to the CPU datapath (PC, accumulator); active-high.
- `done`  out  1  image loaded; CPU released.
- `err`  out  1  malformed or corrupt image.

## Operation
- Frame format: `SYNC_BYTE`, then count byte N, then N words sent high byte first, then (with `IM_LOADER_CHECKSUM_EN`) one checksum byte.
- A byte is accepted on a rising edge where `rx_valid & rx_ready` is true.
- State machine (`rx_ready` is 1 in every state except RUN):
  - IDLE: discard bytes other than `SYNC_BYTE`; on `SYNC_BYTE` go to COUNT.
  - COUNT: N in 1..2^ADDR_W loads the word counter and goes to HI with index 0. N=0 or N>2^ADDR_W goes to ERR.
  - HI: latch the high byte and go to LO.
  - LO: on acceptance, register `im_d={hi,lo}`, `im_a=index`, and `im_we=1`. Increment index. Go to HI if more words remain; otherwise go to CHK (macro on) or RUN (macro off).
  - CHK: compare the byte with the XOR of all 2N data bytes. Match goes to RUN; mismatch goes to ERR.
  - RUN: `cpu_rst=0`, `done=1`, `rx_ready=0`. Input is ignored. Exit only via `rst`.
  - ERR: `err=1`, `cpu_rst=1`. Accepting `SYNC_BYTE` clears `err`, resets index and checksum, and goes to COUNT. Other bytes are discarded.
- Words already written before an error stay in memory; the CPU is never released on a bad image.
- Addresses written are 0..N-1. Locations N..2^ADDR_W-1 are untouched.

## Timing
- Reset values: state IDLE, `cpu_rst=1`, `im_we=0`, `im_a=0`, `im_d=0`, `done=0`, `err=0`. `rx_ready=1`, since it is combinational from the state.
- `im_we`, `im_a`, `im_d` are registered. If the low byte is accepted at edge k, they are valid from k until k+1, and the IM write completes at edge k+1. `im_we` returns to 0 at k+1 unless another low byte is accepted at k+1.
- Maximum throughput is one byte per cycle, with no back-pressure while loading.
- `cpu_rst` and `done` change at the edge after the transition into RUN. The last word's write edge therefore coincides with or precedes CPU release, and the CPU's first active edge sees the full image.
- `err` is asserted at the edge the fault byte is accepted.
- Asserting `rst` mid-load aborts immediately to reset values. Partial IM contents remain.

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined: the CHK state exists, one trailing XOR checksum byte is required, and a mismatch goes to ERR.
- `IM_LOADER_CHECKSUM_EN` undefined: there is no CHK state and no checksum register. RUN is entered directly after the last low byte, and `err` can only come from a bad count.

## Structure
- Shared package `im_loader_pkg`:
  - state enum (IDLE, COUNT, HI, LO, CHK, RUN, ERR);
  - default `SYNC_BYTE` constant 8'hA5;
  - `IM_WORD_W=16`.
- Single module. No sub-module is warranted; the checksum is a single XOR register inside the `ifdef`.

## Test plan
- Stream A5,02,12,34,AB,CD (+ checksum 40 if enabled), one byte per cycle → `im_we` pulses twice: (a=0, d=1234), then (a=1, d=ABCD). `cpu_rst` falls and `done` rises one edge after the final byte; `rx_ready=0` afterward.
- Bytes 00,FF,A5,01,00,0F,(0F) → leading bytes discarded; one write (a=0, d=000F); `done=1`.
- A5,00 → `err=1` with no `im_we`; then A5,01,11,22,(33) → `err` clears, write (a=0, d=1122), `done=1`.
- With checksum enabled, A5,01,11,22,00 → write occurs, `err=1`, `cpu_rst` stays 1, `done=0`.
- Assert `rst` after A5,03,12 → all outputs return to reset values immediately. A fresh frame then loads correctly from address 0.
- `rx_valid` toggling every other cycle during a 32-word (N=0x20) frame → 32 writes to addresses 0..31, with no dropped or duplicated bytes.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared types and constants for the boot-time program loader.
// Holds the loader state enum, the default sync byte and the IM word width.
package im_loader_pkg;

    localparam int          IM_WORD_W         = 16;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_e;

endpackage

// File: rtl/im_loader.sv
// im_loader: byte-stream program loader feeding the instruction memory write port.
// Frame: SYNC_BYTE, count N, N words (high byte first), optional XOR checksum byte.
// Holds the CPU in reset until a complete, valid image has been written.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_data/valid/ready byte stream input (valid/ready handshake)
//   im_a, im_d, im_we   registered instruction-memory write port
//   cpu_rst             CPU datapath reset, released once the image is loaded
//   done                image loaded, CPU running
//   err                 malformed or corrupt image
//
// Build option: IM_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [ADDR_W-1:0]    im_a,
    output logic [IM_WORD_W-1:0] im_d,
    output logic                 im_we,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 err
);

    // Largest legal count, widened so 2^ADDR_W itself is representable.
    localparam logic [8:0] MAX_N = 9'(1 << ADDR_W);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]      last_q, last_d;
    logic [7:0]             hi_q, hi_d;
    logic [ADDR_W-1:0]      im_a_q, im_a_d;
    logic [IM_WORD_W-1:0]   im_d_q, im_d_d;
    logic                   im_we_q, im_we_d;
    logic                   err_q, err_d;
    logic                   cpu_rst_q;
    logic                   done_q;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]             chk_q, chk_d;
`endif

    logic                   acc;
    logic                   is_sync;
    logic                   cnt_ok;

    assign rx_ready = (state_q != ST_RUN);
    assign acc      = rx_valid & rx_ready;
    assign is_sync  = (rx_data == SYNC_BYTE);
    assign cnt_ok   = (rx_data != 8'd0) && ({1'b0, rx_data} <= MAX_N);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hi_d    = hi_q;
        im_a_d  = im_a_q;
        im_d_d  = im_d_q;
        im_we_d = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (acc && is_sync) begin
                    state_d = ST_COUNT;
                    idx_d   = '0;
`ifdef IM_LOADER_CHECKSUM_EN
                    chk_d   = 8'd0;
`endif
                end
            end
            ST_COUNT: begin
                if (acc) begin
                    if (cnt_ok) begin
                        // Store N-1 so the last word is an equality test.
                        last_d  = ADDR_W'(rx_data - 8'd1);
                        idx_d   = '0;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_HI: begin
                if (acc) begin
                    hi_d    = rx_data;
`ifdef IM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (acc) begin
                    im_we_d = 1'b1;
                    im_a_d  = idx_q;
                    im_d_d  = {hi_q, rx_data};
                    idx_d   = idx_q + ADDR_W'(1);
`ifdef IM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    if (idx_q == last_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (acc) begin
                    state_d = (rx_data == chk_q) ? ST_RUN : ST_ERR;
                end
            end
`endif
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // err follows the state so it rises on the edge the bad byte lands.
        err_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            last_q    <= '0;
            hi_q      <= 8'd0;
            im_a_q    <= '0;
            im_d_q    <= '0;
            im_we_q   <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            hi_q      <= hi_d;
            im_a_q    <= im_a_d;
            im_d_q    <= im_d_d;
            im_we_q   <= im_we_d;
            err_q     <= err_d;
            // Release lags RUN entry by one edge so the final IM write
            // lands no later than the CPU's first active edge.
            cpu_rst_q <= (state_q != ST_RUN);
            done_q    <= (state_q == ST_RUN);
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 8'd0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    assign im_a    = im_a_q;
    assign im_d    = im_d_q;
    assign im_we   = im_we_q;
    assign err     = err_q;
    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized self-checking bench for im_loader.
// Frames are built from word lists; expected writes and outcome come from a frame-level model.
module tb_im_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [7:0] SYNC = 8'hA5;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] im_a;
    logic [15:0]       im_d;
    logic              im_we;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int checks;
    int failures;

    logic [15:0] wbuf [0:255];
    int          exp_a [$];
    logic [15:0] exp_d [$];

    im_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_a     (im_a),
        .im_d     (im_d),
        .im_we    (im_we),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the next expected (address, word).
    always @(negedge clk) begin
        if (!rst && im_we) begin
            if (exp_a.size() == 0) begin
                check("unexpected_we", {31'd0, im_we}, 32'd0);
            end else begin
                check("we_addr", 32'(im_a), 32'(exp_a.pop_front()));
                check("we_data", 32'(im_d), 32'(exp_d.pop_front()));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        check({tag, "_im_we"},    32'(im_we),    32'd0);
        check({tag, "_im_a"},     32'(im_a),     32'd0);
        check({tag, "_im_d"},     32'(im_d),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        exp_a.delete();
        exp_d.delete();
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit pick_gap(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return ($urandom_range(0, 2) == 0);
        return 1'b0;
    endfunction

    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        check("rx_ready_on_send", 32'(rx_ready), 32'd1);
        @(posedge clk);
    endtask

    // Sends one frame of n words from wbuf. cmask != 0 corrupts the checksum.
    task automatic run_frame(input logic [7:0] n, input logic [7:0] cmask,
                             input int gmode);
        logic [7:0] x;
        bit         bad;
        x   = 8'd0;
        bad = 1'b0;
        send(SYNC, pick_gap(gmode));
        send(n, pick_gap(gmode));
        if (n == 8'd0 || int'(n) > DEPTH) begin
            @(negedge clk);
            rx_valid = 1'b0;
            check("cnt_err",     32'(err),     32'd1);
            check("cnt_cpu_rst", 32'(cpu_rst), 32'd1);
            @(negedge clk);
            check("cnt_done",    32'(done),    32'd0);
            check("cnt_err2",    32'(err),     32'd1);
            #1;
            check("cnt_no_writes", 32'(exp_a.size()), 32'd0);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            exp_a.push_back(i);
            exp_d.push_back(wbuf[i]);
            x = x ^ wbuf[i][15:8] ^ wbuf[i][7:0];
            send(wbuf[i][15:8], pick_gap(gmode));
            send(wbuf[i][7:0], pick_gap(gmode));
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send(x ^ cmask, pick_gap(gmode));
        bad = (cmask != 8'd0);
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        check("end_done_early",    32'(done),    32'd0);
        check("end_cpu_rst_early", 32'(cpu_rst), 32'd1);
        check("end_err",           32'(err),     32'(bad));
        @(negedge clk);
        #1;
        check("end_done",     32'(done),     32'(!bad));
        check("end_cpu_rst",  32'(cpu_rst),  32'(bad));
        check("end_rx_ready", 32'(rx_ready), 32'(bad));
        check("end_err2",     32'(err),      32'(bad));
        check("writes_left",  32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] cm;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #2;
        check_reset_vals("por");
        do_reset();

        // Two-word directed frame.
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        run_frame(8'd2, 8'd0, 0);

        // Leading junk is discarded.
        do_reset();
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        wbuf[0] = 16'h000F;
        run_frame(8'd1, 8'd0, 0);

        // Zero count errors, then a good frame recovers.
        do_reset();
        run_frame(8'd0, 8'd0, 0);
        wbuf[0] = 16'h1122;
        run_frame(8'd1, 8'd0, 0);

`ifdef IM_LOADER_CHECKSUM_EN
        // Wrong checksum (00 instead of 33).
        do_reset();
        wbuf[0] = 16'h1122;
        run_frame(8'd1, 8'h33, 0);
`endif

        // Reset mid-load, then a fresh frame from address 0.
        do_reset();
        send(SYNC, 1'b0);
        send(8'd3, 1'b0);
        send(8'h12, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
        run_frame(8'd3, 8'd0, 0);

        // Full-size frame with valid toggling every other cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) wbuf[i] = 16'($urandom);
        run_frame(8'(DEPTH), 8'd0, 1);

        // Oversize count.
        do_reset();
        run_frame(8'(DEPTH + 1), 8'd0, 0);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            do_reset();
            if ($urandom_range(0, 1) == 1) begin
                send(8'($urandom_range(0, 8'hA4)), 1'b0);
            end
            if ($urandom_range(0, 7) == 0) begin
                n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(DEPTH + 1, 255);
            end else begin
                n = $urandom_range(1, DEPTH);
            end
            cm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
            run_frame(8'(n), cm, 2);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
